// File: rtl/ac_motor_vector_pwm.sv
// ac_motor_vector_pwm
// Plays one sampling period of space-vector PWM out of four dwell times
// (zero 000, active Va, active Vb, zero 111). Each inverter leg gets
// complementary high/low gate drives with a dead-time gap on every switch.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   ENABLE               modulator enable, sampled at period start
//   SECTOR[2:0]          voltage sector 1..6 (0 and 7 raise FAULT)
//   T_0/T_1/T_2/T_7      dwell times in clock cycles (15 bit each)
//   HI_x / LO_x          high/low side gate commands for legs A, B, C
//   PERIOD_START         one-cycle pulse per period, coincident with new shadow values
//   OVR                  dwell sum of the current period exceeds the period length
//   FAULT                illegal sector latched for the current period
module ac_motor_vector_pwm #(
    parameter int F_CLK  = 100*10**6,
    parameter int F_TAST = 10*10**3,
    parameter int DEAD   = 100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [2:0]  SECTOR,
    input  logic [14:0] T_0,
    input  logic [14:0] T_1,
    input  logic [14:0] T_2,
    input  logic [14:0] T_7,
    output logic        HI_A,
    output logic        HI_B,
    output logic        HI_C,
    output logic        LO_A,
    output logic        LO_B,
    output logic        LO_C,
    output logic        PERIOD_START,
    output logic        OVR,
    output logic        FAULT
);

    localparam int                T_TAST    = F_CLK / F_TAST;
    localparam int                CNT_W     = $clog2(T_TAST);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(T_TAST - 1);
    localparam logic [16:0]       T_TAST_17 = 17'(T_TAST);
    localparam logic [7:0]        DEAD_LD   = 8'(DEAD);

    // Vector bits are {A,B,C}.
    function automatic logic [2:0] vec_of(input logic [2:0] k);
        case (k)
            3'd1:    vec_of = 3'b100;
            3'd2:    vec_of = 3'b110;
            3'd3:    vec_of = 3'b010;
            3'd4:    vec_of = 3'b011;
            3'd5:    vec_of = 3'b001;
            3'd6:    vec_of = 3'b101;
            default: vec_of = 3'b000;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             period_start_q, period_start_d;
    logic [16:0]      b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic [2:0]       sector_q, sector_d;
    logic             en_q, en_d;
    logic             ovr_q, ovr_d;
    logic             fault_q, fault_d;
    logic [2:0]       ph_q, ph_d;
    logic [2:0]       hi_q, hi_d, lo_q, lo_d;
    logic [2:0][7:0]  dt_q, dt_d;

    logic             load;
    logic             off_q, off_d;
    logic [16:0]      cnt_ext;
    logic [2:0]       va, vb, nxt_sector;
    logic [2:0]       chg;

    always_comb begin
        load           = (cnt_q == '0);
        cnt_d          = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        period_start_d = load;

        b1_d     = b1_q;
        b2_d     = b2_q;
        b3_d     = b3_q;
        sector_d = sector_q;
        en_d     = en_q;
        ovr_d    = ovr_q;
        fault_d  = fault_q;

        if (load) begin
            sector_d = SECTOR;
            en_d     = ENABLE;
            b1_d     = {2'b00, T_0};
            b2_d     = b1_d + {2'b00, T_1};
            b3_d     = b2_d + {2'b00, T_2};
            ovr_d    = (b3_d + {2'b00, T_7}) > T_TAST_17;
            fault_d  = (SECTOR == 3'd0) || (SECTOR == 3'd7);
        end

        // PH for count c uses the values the period will run with, so the
        // shadow being loaded at c==0 already governs the first segment.
        off_q      = !en_q || fault_q;
        off_d      = !en_d || fault_d;
        cnt_ext    = 17'(cnt_q);
        nxt_sector = (sector_d == 3'd6) ? 3'd1 : sector_d + 3'd1;
        va         = vec_of(sector_d);
        vb         = vec_of(nxt_sector);

        if (off_d)                 ph_d = 3'b000;
        else if (cnt_ext < b1_d)   ph_d = 3'b000;
        else if (cnt_ext < b2_d)   ph_d = va;
        else if (cnt_ext < b3_d)   ph_d = vb;
        else                       ph_d = 3'b111;

        // Coming out of the disabled/fault state counts as a switch so the
        // dead time is honoured before any gate is driven.
        for (int i = 0; i < 3; i++) begin
            chg[i]  = (ph_d[i] != ph_q[i]) || (off_q && !off_d);
            dt_d[i] = chg[i] ? DEAD_LD : ((dt_q[i] != 8'd0) ? dt_q[i] - 8'd1 : 8'd0);
            hi_d[i] = !chg[i] && (dt_q[i] == 8'd0) && !off_d && ph_d[i];
            lo_d[i] = !chg[i] && (dt_q[i] == 8'd0) && !off_d && !ph_d[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            b1_q           <= '0;
            b2_q           <= '0;
            b3_q           <= '0;
            sector_q       <= '0;
            en_q           <= 1'b0;
            ovr_q          <= 1'b0;
            fault_q        <= 1'b0;
            ph_q           <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            dt_q           <= '0;
        end else begin
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
            b1_q           <= b1_d;
            b2_q           <= b2_d;
            b3_q           <= b3_d;
            sector_q       <= sector_d;
            en_q           <= en_d;
            ovr_q          <= ovr_d;
            fault_q        <= fault_d;
            ph_q           <= ph_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            dt_q           <= dt_d;
        end
    end

    assign HI_A         = hi_q[2];
    assign HI_B         = hi_q[1];
    assign HI_C         = hi_q[0];
    assign LO_A         = lo_q[2];
    assign LO_B         = lo_q[1];
    assign LO_C         = lo_q[0];
    assign PERIOD_START = period_start_q;
    assign OVR          = ovr_q;
    assign FAULT        = fault_q;

endmodule

// File: tb/tb_ac_motor_vector_pwm.sv
// Bench for ac_motor_vector_pwm, run with a 1000-cycle period (F_TAST=100 kHz)
// and DEAD=10; dwell times are the nominal scenario scaled by 1/10.
// Observation index n counts negedges from the PERIOD_START cycle; the gate
// state at index n reflects period count n.
module tb_ac_motor_vector_pwm;

    localparam int T    = 1000;
    localparam int DEAD = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  sector = 3'd0;
    logic [14:0] t0 = '0, t1 = '0, t2 = '0, t7 = '0;
    logic        HI_A, HI_B, HI_C, LO_A, LO_B, LO_C;
    logic        PERIOD_START, OVR, FAULT;

    always #5 clk = ~clk;

    ac_motor_vector_pwm #(
        .F_CLK (100_000_000),
        .F_TAST(100_000),
        .DEAD  (DEAD)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .ENABLE      (enable),
        .SECTOR      (sector),
        .T_0         (t0),
        .T_1         (t1),
        .T_2         (t2),
        .T_7         (t7),
        .HI_A        (HI_A),
        .HI_B        (HI_B),
        .HI_C        (HI_C),
        .LO_A        (LO_A),
        .LO_B        (LO_B),
        .LO_C        (LO_C),
        .PERIOD_START(PERIOD_START),
        .OVR         (OVR),
        .FAULT       (FAULT)
    );

    typedef struct {
        logic [2:0] sector;
        logic       en;
        int         t0, t1, t2, t7;
        int         mid_n;      // index at which inputs change mid-period, -1 for none
        int         mid_t1;
        logic       mid_en;
        int         b1, b2, b3; // expected segment boundaries
        logic [2:0] va, vb;
        logic       ovr, fault;
    } vec_t;

    vec_t vecs[15];

    int n_cmp = 0;
    int n_fail = 0;

    logic [2:0] m_ph;
    logic       m_off;
    int         last_chg[3];
    int         abs_t;
    int         rise;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        n_cmp++;
        if ((HI_A && LO_A) || (HI_B && LO_B) || (HI_C && LO_C)) begin
            n_fail++;
            $display("FAIL shoot_through: hi=%b%b%b lo=%b%b%b, expected no leg with both",
                     HI_A, HI_B, HI_C, LO_A, LO_B, LO_C);
        end
    end

    task automatic run_vec(input int idx, input int stop_n, output int rise_a);
        vec_t       v;
        logic       off;
        logic [2:0] ph, exp_hi, exp_lo;
        logic       hia_prev;
        v      = vecs[idx];
        sector = v.sector;
        enable = v.en;
        t0     = 15'(v.t0);
        t1     = 15'(v.t1);
        t2     = 15'(v.t2);
        t7     = 15'(v.t7);
        off    = !v.en || v.fault;
        rise_a = -1;
        hia_prev = HI_A;
        for (int n = 0; n < stop_n; n++) begin
            @(negedge clk);
            if (off)           ph = 3'b000;
            else if (n < v.b1) ph = 3'b000;
            else if (n < v.b2) ph = v.va;
            else if (n < v.b3) ph = v.vb;
            else               ph = 3'b111;
            for (int x = 0; x < 3; x++) begin
                if ((ph[x] != m_ph[x]) || (m_off && !off)) last_chg[x] = abs_t;
                if (off || (abs_t - last_chg[x] <= DEAD)) begin
                    exp_hi[x] = 1'b0;
                    exp_lo[x] = 1'b0;
                end else begin
                    exp_hi[x] = ph[x];
                    exp_lo[x] = ~ph[x];
                end
            end
            m_ph  = ph;
            m_off = off;
            abs_t++;
            check($sformatf("v%0d gates n=%0d", idx, n),
                  int'({HI_A, HI_B, HI_C, LO_A, LO_B, LO_C}), int'({exp_hi, exp_lo}));
            check($sformatf("v%0d period_start n=%0d", idx, n), int'(PERIOD_START), int'(n == 0));
            if (n == 0 || n == stop_n - 1) begin
                check($sformatf("v%0d ovr n=%0d", idx, n), int'(OVR), int'(v.ovr));
                check($sformatf("v%0d fault n=%0d", idx, n), int'(FAULT), int'(v.fault));
            end
            if (HI_A && !hia_prev && rise_a < 0) rise_a = n;
            hia_prev = HI_A;
            if (n == v.mid_n) begin
                t1     = 15'(v.mid_t1);
                enable = v.mid_en;
            end
        end
    endtask

    initial begin
        //           sec  en  t0   t1   t2   t7  mid  mt1  men  b1   b2   b3    va      vb     ovr  flt
        vecs[0]  = '{3'd1, 1, 250, 300, 200, 250, -1,   0, 0, 250, 550,  750, 3'b100, 3'b110, 0, 0};
        vecs[1]  = '{3'd1, 1, 100, 300, 300, 300, -1,   0, 0, 100, 400,  700, 3'b100, 3'b110, 0, 0};
        vecs[2]  = '{3'd2, 1, 100, 300, 300, 300, -1,   0, 0, 100, 400,  700, 3'b110, 3'b010, 0, 0};
        vecs[3]  = '{3'd3, 1, 100, 300, 300, 300, -1,   0, 0, 100, 400,  700, 3'b010, 3'b011, 0, 0};
        vecs[4]  = '{3'd4, 1, 100, 300, 300, 300, -1,   0, 0, 100, 400,  700, 3'b011, 3'b001, 0, 0};
        vecs[5]  = '{3'd5, 1, 100, 300, 300, 300, -1,   0, 0, 100, 400,  700, 3'b001, 3'b101, 0, 0};
        vecs[6]  = '{3'd6, 1, 100, 300, 300, 300, -1,   0, 0, 100, 400,  700, 3'b101, 3'b100, 0, 0};
        vecs[7]  = '{3'd1, 1, 300, 400, 400, 300, -1,   0, 0, 300, 700, 1100, 3'b100, 3'b110, 1, 0};
        vecs[8]  = '{3'd2, 1, 250, 300, 200, 250, -1,   0, 0, 250, 550,  750, 3'b110, 3'b010, 0, 0};
        vecs[9]  = '{3'd0, 1, 250, 300, 200, 250, -1,   0, 0, 250, 550,  750, 3'b000, 3'b000, 0, 1};
        vecs[10] = '{3'd7, 1, 250, 300, 200, 250, -1,   0, 0, 250, 550,  750, 3'b000, 3'b000, 0, 1};
        vecs[11] = '{3'd1, 0, 250, 300, 200, 250, 300, 300, 1, 250, 550,  750, 3'b100, 3'b110, 0, 0};
        vecs[12] = '{3'd1, 1, 250, 300, 200, 250, 500,   0, 1, 250, 550,  750, 3'b100, 3'b110, 0, 0};
        vecs[13] = '{3'd1, 1, 250,   0, 200, 250, -1,   0, 0, 250, 250,  450, 3'b100, 3'b110, 0, 0};
        vecs[14] = '{3'd3, 1,   0, 300, 200, 500, -1,   0, 0,   0, 300,  500, 3'b010, 3'b011, 0, 0};

        m_ph  = 3'b000;
        m_off = 1'b1;
        abs_t = 0;
        for (int x = 0; x < 3; x++) last_chg[x] = -1000;

        repeat (3) @(negedge clk);
        check("reset gates", int'({HI_A, HI_B, HI_C, LO_A, LO_B, LO_C}), 0);
        check("reset period_start", int'(PERIOD_START), 0);
        check("reset ovr", int'(OVR), 0);
        check("reset fault", int'(FAULT), 0);

        rst_n = 1'b1;
        run_vec(0, T, rise);
        check("nominal hi_a rise index", rise, 261);
        for (int i = 1; i < 15; i++) begin
            run_vec(i, T, rise);
            if (i == 13) check("t1=0 hi_a rise index", rise, 261);
        end

        // Reset in the middle of a period, while HI_A/LO_B/LO_C are driven.
        run_vec(0, 401, rise);
        #1 rst_n = 1'b0;
        #1;
        check("async reset gates", int'({HI_A, HI_B, HI_C, LO_A, LO_B, LO_C}), 0);
        check("async reset ovr/fault/ps", int'({OVR, FAULT, PERIOD_START}), 0);
        @(negedge clk);
        check("reset hold gates", int'({HI_A, HI_B, HI_C, LO_A, LO_B, LO_C}), 0);
        m_ph  = 3'b000;
        m_off = 1'b1;
        rst_n = 1'b1;
        run_vec(0, T, rise);
        check("post-reset hi_a rise index", rise, 261);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ac_motor_vector_pwm.md
Name: ac_motor_vector_pwm

Overview:
- Consumer side of the vector dwell-time calculation: takes dwell times T_0/T_1/T_2/T_7 and the sector number, and plays them out as a 4-segment space-vector switching sequence for one sampling period.
- Produces complementary high/low gate signals for the three inverter legs, with per-leg dead time.
- Sits between the dwell-time block and the inverter gate drivers.

Parameters:
- F_CLK, 100*10**6, clock frequency in Hz.
- F_TAST, 10*10**3, sampling/PWM frequency in Hz.
- T_TAST, F_CLK/F_TAST (10000), period length in clock cycles.
- DEAD, 100, dead time in clock cycles; legal range 1..255.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous reset, active-low.
- ENABLE  in  1  modulator enable; sampled at period start.
- SECTOR  in  3  voltage sector; legal values 1..6.
- T_0  in  15  zero-vector (000) dwell time, in cycles.
- T_1  in  15  first active-vector dwell time, in cycles.
- T_2  in  15  second active-vector dwell time, in cycles.
- T_7  in  15  zero-vector (111) dwell time, in cycles.
- HI_A, HI_B, HI_C  out  1 each  high-side gate commands.
- LO_A, LO_B, LO_C  out  1 each  low-side gate commands.
- PERIOD_START  out  1  one-cycle pulse when the period counter is 0.
- OVR  out  1  the current period's dwell sum exceeded T_TAST.
- FAULT  out  1  the current period latched an illegal sector.

Behaviour:
- Reset (async, RST_N=0):
  - All HI_x/LO_x = 0; PERIOD_START, OVR, FAULT = 0.
  - Period counter CNT = 0; shadow registers = 0; shadow enable = 0; PH = 000; dead-time counters = 0.
  - A reset mid-period forces all gates off immediately.
- Period counter:
  - CNT counts 0..T_TAST-1 and wraps to 0.
  - PERIOD_START is registered and high for exactly one cycle per period.
  - After reset release, the first cycle has CNT=0.
- Shadow load:
  - When CNT==0, latch T_0..T_7, SECTOR and ENABLE.
  - Also compute b1=T_0, b2=T_0+T_1, b3=T_0+T_1+T_2 as 17-bit unsigned values.
  - OVR = (T_0+T_1+T_2+T_7 > T_TAST), held for the whole period.
  - FAULT = (SECTOR==0 or SECTOR==7), held for the whole period.
  - Input changes at CNT!=0 have no effect until the next wrap.
- Switching vectors, written as (A,B,C): V1=100, V2=110, V3=010, V4=011, V5=001, V6=101. Sector k uses Va=Vk and Vb=V((k mod 6)+1).
- Phase command PH, registered, using the count c of the previous cycle:
  - c<b1: 000
  - b1<=c<b2: Va
  - b2<=c<b3: Vb
  - otherwise: 111
  - Zero-length segments are skipped naturally.
  - With overrun, the segment active at T_TAST-1 is truncated; no extension of the period.
  - If shadow ENABLE=0 or FAULT=1, PH=000 and all gates are forced to 0 for the whole period.
- Dead time, per leg:
  - On any change of PH_x, both HI_x and LO_x go to 0 in the next cycle and a counter loads DEAD.
  - The counter decrements each cycle. When it reaches 0, HI_x=PH_x and LO_x=~PH_x.
  - The new-side gate therefore asserts DEAD+1 cycles after the PH_x change.
  - A further PH_x change during dead time reloads the counter; no gate asserts in between.
  - HI_x and LO_x are never 1 simultaneously, in any state.
- Gates after reset:
  - The first period after reset has shadow ENABLE sampled at CNT=0.
  - Leaving the disabled/fault state behaves like a PH change: dead time applies before any gate asserts.
- Arithmetic: unsigned throughout, no saturation on inputs. Comparisons use 17-bit sums so 15-bit inputs cannot overflow.

Test Plan:
- Nominal, sector 1: DEAD=10, ENABLE=1, T_0=2500, T_1=3000, T_2=2000, T_7=2500. Required:
  - PH=000 for counts 0..2499, 100 for 2500..5499, 110 for 5500..7499, 111 for 7500..9999.
  - HI_A rises 11 cycles after PH_A rises.
  - OVR=0, FAULT=0.
  - PERIOD_START period is 10000 cycles.
- Sector sweep: SECTOR 1..6 with fixed times. Required:
  - Va/Vb follow V1V2, V2V3, V3V4, V4V5, V5V6, V6V1.
  - Sector 6 active segment 1 = 101, segment 2 = 100.
- Overrun: T_0=3000, T_1=4000, T_2=4000, T_7=3000. Required:
  - OVR=1 for the whole period.
  - Vb is held from count 7000 to 9999; 111 never appears.
  - The next period with legal times clears OVR.
- Illegal sector / disable: SECTOR=0 gives FAULT=1 and all gates 0 for the full period. ENABLE=0 at CNT=0 gives all gates 0 even if ENABLE rises mid-period.
- Shadowing and zero segments:
  - Changing T_1 at count 5000 takes effect only after the next PERIOD_START.
  - T_1=0 gives a direct 000-to-Vb transition.
  - T_0=0 gives Va from count 0.
- Reset mid-period: assert RST_N=0 at count 4000. Required:
  - All gates go to 0 asynchronously.
  - After release, CNT restarts at 0 and PERIOD_START pulses in the first cycle.
  - HI/LO are never both 1 on any leg (checked by assertion throughout every test).
